operand_collector: RTL and testbench
====================================

# operand_collector

Fetches source operands from `register_block` for an issued instruction and presents them as a registered operand bundle to the execute stage. It owns the register block's read ports and shared `warp_selector`, and passes writebacks through with priority. It sits between the scheduler and the ALU lanes: 8 lanes, 32 registers, 32-bit data, 8 warps.

## Interface
Parameters:
- `LANES`, 8, SIMD lanes per warp
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width (32 registers)
- `WARP_W`, 3, warp id width (8 warps)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  instruction issue valid
- `req_ready`  out  1  collector can accept a request
- `req_warp`  in  WARP_W  warp id
- `req_rs1`, `req_rs2`  in  ADDR_W  source register addresses
- `req_rs2_en`  in  1  second operand required
- `req_mask`  in  LANES  active-lane mask
- `wb_valid`  in  1  writeback request (never stalled)
- `wb_warp`  in  WARP_W  writeback warp
- `wb_addr`  in  ADDR_W  writeback register
- `wb_mask`  in  LANES  writeback lane enables
- `wb_data`  in  LANES*DATA_W  writeback data; lane i at bits [i*DATA_W +: DATA_W]
- `rb_read_en_0`, `rb_read_en_1`  out  LANES  register block per-lane read enables
- `rb_raddr_0`, `rb_raddr_1`  out  ADDR_W  register block read addresses
- `rb_write_en`  out  LANES  register block write enables
- `rb_waddr`  out  ADDR_W  register block write address
- `rb_wdata`  out  LANES*DATA_W  register block write data, lane-packed
- `rb_warp_selector`  out  WARP_W  register block warp select
- `rb_rdata_0`, `rb_rdata_1`  in  LANES*DATA_W  register block read data, combinational from address and enable
- `op_valid`  out  1  operand bundle valid
- `op_ready`  in  1  execute stage accepts bundle
- `op_warp`  out  WARP_W  bundle warp
- `op_mask`  out  LANES  bundle lane mask
- `op_a`, `op_b`  out  LANES*DATA_W  operand values

## Operation
- One pending-request register (`pend`, warp, rs1, rs2, rs2_en, mask) and one output register (`op_*`).
- Two states: IDLE (`pend`=0) and FETCH (`pend`=1).
- Accept: a request is accepted when `req_valid && req_ready`. `req_ready = !rst && (!pend || read_fire)`.
- `out_free = !op_valid || op_ready`.
- `read_fire = pend && out_free && !wb_block`. `wb_block = wb_valid` (see Configuration).
- Writeback cycle (`wb_valid`=1):
  - Drive `rb_warp_selector=wb_warp`, `rb_write_en=wb_mask`, `rb_waddr=wb_addr`, `rb_wdata=wb_data`.
  - The write commits at the rising edge.
- Read cycle (`read_fire`):
  - Drive `rb_warp_selector`=pending warp, `rb_raddr_0`=rs1, `rb_raddr_1`=rs2.
  - Drive `rb_read_en_0`=mask, and `rb_read_en_1`=mask if rs2_en, else 0.
  - Capture at the edge: `op_a`/`op_b` lane i = rdata lane i if its mask bit is set, else 0; `op_b` = 0 when !rs2_en.
  - At the same edge: `op_valid`←1, `op_warp`/`op_mask` ← pending values.
- `op_valid` clears on `op_ready` when there is no simultaneous `read_fire`.
- FETCH→IDLE on `read_fire` without a new accept; FETCH→FETCH on `read_fire` with an accept; IDLE→FETCH on accept.
- Idle cycles with no writeback and no read: all `rb_*` enables are 0, addresses hold their last value, and `rb_warp_selector` holds.
- `op_*` are stable while `op_valid && !op_ready`.

## Timing
- Reset values:
  - `op_valid`=0, `op_warp`=0, `op_mask`=0, `op_a`=0, `op_b`=0, `pend`=0.
  - All `rb_*` outputs 0, `req_ready`=0 while `rst`=1.
- Latency: request accepted at edge N; `op_valid` high after edge N+1 if the path is unblocked. Each `wb_valid` or back-pressure cycle adds one cycle.
- Throughput: one request per cycle when `op_ready` is held high and there are no writebacks.
- Read-after-write: a writeback at edge N is visible to a read in cycle N+1 with no extra stall.
- Reset mid-operation: the pending request and output bundle are discarded, with no partial write.

## Configuration
- `OPERAND_COLLECTOR_WB_BYPASS_EN`
- Undefined: any `wb_valid` blocks reads (`wb_block = wb_valid`).
- Defined: `wb_block = wb_valid && wb_warp != pending warp`.
  - With the same warp, the write and reads are driven in the same cycle.
  - For each operand whose address equals `wb_addr`, lanes set in `wb_mask & mask` take `wb_data` instead of rdata.

## Test plan
- Write lane i = 32'hA0+i to warp 3, reg 5. Then request warp 3, rs1=5, rs2_en=0, mask=8'hFF → `op_valid` 2 cycles after `req_valid`; `op_a` lane i = 32'hA0+i; `op_b`=0.
- Request with mask=8'h0F, rs1=rs2=5 → lanes 4–7 of `op_a`/`op_b` are 0; `rb_read_en_0` and `rb_read_en_1` = 8'h0F.
- `op_ready`=0 for 3 cycles with two requests issued back-to-back → first bundle held stable, `req_ready`=0 after the second accept, no data lost; both bundles are delivered in order.
- `wb_valid` to warp 2, reg 7 (data 32'hDEAD_0000+i) in the read cycle of a warp 2, rs1=7 request. Without the macro: 1-cycle stall, then `op_a`=new data. With the macro: no stall, `op_a`=new data via bypass.
- `wb_valid` to warp 1 during a pending warp 4 read → read stalls 1 cycle in both configurations; `rb_warp_selector`=1 then 4.
- Assert `rst` for 1 cycle with `pend`=1 and `op_valid`=1 → next cycle `op_valid`=0, `req_ready`=1, all `rb_*`=0.

Source files
------------

// File: rtl/operand_collector.sv
// Operand collector: fetches rs1/rs2 for an issued warp instruction from the register block,
// owns its read/write ports and warp select. Optional macro: OPERAND_COLLECTOR_WB_BYPASS_EN.
module operand_collector #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WARP_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WARP_W-1:0]       req_warp,
  input  logic [ADDR_W-1:0]       req_rs1,
  input  logic [ADDR_W-1:0]       req_rs2,
  input  logic                    req_rs2_en,
  input  logic [LANES-1:0]        req_mask,
  input  logic                    wb_valid,
  input  logic [WARP_W-1:0]       wb_warp,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [LANES-1:0]        wb_mask,
  input  logic [LANES*DATA_W-1:0] wb_data,
  output logic [LANES-1:0]        rb_read_en_0,
  output logic [LANES-1:0]        rb_read_en_1,
  output logic [ADDR_W-1:0]       rb_raddr_0,
  output logic [ADDR_W-1:0]       rb_raddr_1,
  output logic [LANES-1:0]        rb_write_en,
  output logic [ADDR_W-1:0]       rb_waddr,
  output logic [LANES*DATA_W-1:0] rb_wdata,
  output logic [WARP_W-1:0]       rb_warp_selector,
  input  logic [LANES*DATA_W-1:0] rb_rdata_0,
  input  logic [LANES*DATA_W-1:0] rb_rdata_1,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [WARP_W-1:0]       op_warp,
  output logic [LANES-1:0]        op_mask,
  output logic [LANES*DATA_W-1:0] op_a,
  output logic [LANES*DATA_W-1:0] op_b
);

  localparam int BUS_W = LANES * DATA_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state_q, state_d;

  logic              vld_p0;
  logic [WARP_W-1:0] warp_p0;
  logic [ADDR_W-1:0] rs1_p0;
  logic [ADDR_W-1:0] rs2_p0;
  logic              rs2_en_p0;
  logic [LANES-1:0]  mask_p0;

  logic              vld_p1;
  logic [WARP_W-1:0] warp_p1;
  logic [LANES-1:0]  mask_p1;
  logic [BUS_W-1:0]  a_p1;
  logic [BUS_W-1:0]  b_p1;

  logic [WARP_W-1:0] last_warp;
  logic [ADDR_W-1:0] last_raddr_0;
  logic [ADDR_W-1:0] last_raddr_1;
  logic [ADDR_W-1:0] last_waddr;

  logic             accept;
  logic             out_free;
  logic             wb_block;
  logic             read_fire;
  logic             byp_a;
  logic             byp_b;
  logic [LANES-1:0] b_lanes;

  // Select each lane from read data or, when bypassing, from the concurrent writeback.
  function automatic logic [BUS_W-1:0] gather(
    input logic [BUS_W-1:0] rdata,
    input logic [LANES-1:0] lane_en,
    input logic             bypass,
    input logic [LANES-1:0] wb_lanes,
    input logic [BUS_W-1:0] wb_bus
  );
    logic [BUS_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        if (bypass && wb_lanes[i]) r[i*DATA_W +: DATA_W] = wb_bus[i*DATA_W +: DATA_W];
        else                       r[i*DATA_W +: DATA_W] = rdata[i*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  assign vld_p0   = (state_q == FETCH);
  assign out_free = !vld_p1 || op_ready;

`ifdef OPERAND_COLLECTOR_WB_BYPASS_EN
  // Same-warp writeback shares the warp select with the read, so it can proceed.
  assign wb_block = wb_valid && (wb_warp != warp_p0);
  assign byp_a    = wb_valid && (wb_addr == rs1_p0);
  assign byp_b    = wb_valid && (wb_addr == rs2_p0);
`else
  assign wb_block = wb_valid;
  assign byp_a    = 1'b0;
  assign byp_b    = 1'b0;
`endif

  assign read_fire = !rst && vld_p0 && out_free && !wb_block;
  assign req_ready = !rst && (!vld_p0 || read_fire);
  assign accept    = req_valid && req_ready;
  assign b_lanes   = rs2_en_p0 ? mask_p0 : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (read_fire && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rb_read_en_0     = '0;
    rb_read_en_1     = '0;
    rb_write_en      = '0;
    rb_wdata         = '0;
    rb_raddr_0       = last_raddr_0;
    rb_raddr_1       = last_raddr_1;
    rb_waddr         = last_waddr;
    rb_warp_selector = last_warp;
    if (rst) begin
      rb_raddr_0       = '0;
      rb_raddr_1       = '0;
      rb_waddr         = '0;
      rb_warp_selector = '0;
    end else begin
      if (read_fire) begin
        rb_warp_selector = warp_p0;
        rb_raddr_0       = rs1_p0;
        rb_raddr_1       = rs2_p0;
        rb_read_en_0     = mask_p0;
        rb_read_en_1     = b_lanes;
      end
      if (wb_valid) begin
        rb_warp_selector = wb_warp;
        rb_write_en      = wb_mask;
        rb_waddr         = wb_addr;
        rb_wdata         = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_warp    <= '0;
      last_raddr_0 <= '0;
      last_raddr_1 <= '0;
      last_waddr   <= '0;
    end else begin
      last_warp    <= rb_warp_selector;
      last_raddr_0 <= rb_raddr_0;
      last_raddr_1 <= rb_raddr_1;
      last_waddr   <= rb_waddr;
    end
  end

  // Stage p0: pending request held until its read fires.
  always_ff @(posedge clk) begin
    if (accept) begin
      warp_p0   <= req_warp;
      rs1_p0    <= req_rs1;
      rs2_p0    <= req_rs2;
      rs2_en_p0 <= req_rs2_en;
      mask_p0   <= req_mask;
    end
  end

  // Stage p1: registered operand bundle toward execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      warp_p1 <= '0;
      mask_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else if (read_fire) begin
      vld_p1  <= 1'b1;
      warp_p1 <= warp_p0;
      mask_p1 <= mask_p0;
      a_p1    <= gather(rb_rdata_0, mask_p0, byp_a, wb_mask, wb_data);
      b_p1    <= gather(rb_rdata_1, b_lanes, byp_b, wb_mask, wb_data);
    end else if (op_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign op_valid = vld_p1;
  assign op_warp  = warp_p1;
  assign op_mask  = mask_p1;
  assign op_a     = a_p1;
  assign op_b     = b_p1;

endmodule

// File: tb/tb_operand_collector.sv
// Bench for operand_collector: register-block model, directed scenarios, then randomized
// traffic scored against a shadow register file and an in-order bundle queue.
module tb_operand_collector;
  localparam int LANES = 8, DATA_W = 32, ADDR_W = 5, WARP_W = 3;
  localparam int BW = LANES * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req_valid, req_ready, req_rs2_en, wb_valid, op_valid, op_ready;
  logic [WARP_W-1:0] req_warp, wb_warp, rb_warp_selector, op_warp;
  logic [ADDR_W-1:0] req_rs1, req_rs2, wb_addr, rb_raddr_0, rb_raddr_1, rb_waddr;
  logic [LANES-1:0]  req_mask, wb_mask, rb_read_en_0, rb_read_en_1, rb_write_en, op_mask;
  logic [BW-1:0]     wb_data, rb_wdata, rb_rdata_0, rb_rdata_1, op_a, op_b;

  operand_collector dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_warp(req_warp),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs2_en(req_rs2_en), .req_mask(req_mask),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
    .rb_read_en_0(rb_read_en_0), .rb_read_en_1(rb_read_en_1),
    .rb_raddr_0(rb_raddr_0), .rb_raddr_1(rb_raddr_1),
    .rb_write_en(rb_write_en), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
    .rb_warp_selector(rb_warp_selector),
    .rb_rdata_0(rb_rdata_0), .rb_rdata_1(rb_rdata_1),
    .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp), .op_mask(op_mask),
    .op_a(op_a), .op_b(op_b)
  );

  // Register block model: combinational read, write at the rising edge.
  logic [31:0] rf [0:7][0:31][0:7];
  always @(posedge clk)
    for (int i = 0; i < LANES; i++)
      if (rb_write_en[i]) rf[rb_warp_selector][rb_waddr][i] <= rb_wdata[i*32 +: 32];

  always_comb begin
    rb_rdata_0 = '0;
    rb_rdata_1 = '0;
    for (int i = 0; i < LANES; i++) begin
      rb_rdata_0[i*32 +: 32] = rb_read_en_0[i] ? rf[rb_warp_selector][rb_raddr_0][i] : 32'hBAD0_0000 + i;
      rb_rdata_1[i*32 +: 32] = rb_read_en_1[i] ? rf[rb_warp_selector][rb_raddr_1][i] : 32'hBAD1_0000 + i;
    end
  end

  typedef struct packed {
    logic [2:0]    warp;
    logic [7:0]    mask;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
  } bundle_t;

  logic [31:0] shadow [0:7][0:31][0:7];
  bundle_t     expq [$];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] ramp(input logic [31:0] base, input logic [7:0] m);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) if (m[i]) r[i*32 +: 32] = base + i;
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bundle_t expect_bundle(input logic [2:0] w, input logic [4:0] a1,
                                            input logic [4:0] a2, input logic en, input logic [7:0] m);
    bundle_t e;
    e.warp = w;
    e.mask = m;
    e.a = '0;
    e.b = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i])        e.a[i*32 +: 32] = shadow[w][a1][i];
      if (m[i] && en)  e.b[i*32 +: 32] = shadow[w][a2][i];
    end
    return e;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] w, input logic [4:0] a1, input logic [4:0] a2,
                     input logic en, input logic [7:0] m);
    req_valid = 1'b1; req_warp = w; req_rs1 = a1; req_rs2 = a2; req_rs2_en = en; req_mask = m;
  endtask

  task automatic wb_write(input logic [2:0] w, input logic [4:0] a, input logic [7:0] m,
                          input logic [BW-1:0] d, input bit upd);
    wb_valid = 1'b1; wb_warp = w; wb_addr = a; wb_mask = m; wb_data = d;
    if (upd) for (int i = 0; i < LANES; i++) if (m[i]) shadow[w][a][i] = d[i*32 +: 32];
  endtask

  task automatic run_random(input int n, input bit wb_on);
    bundle_t e;
    for (int c = 0; c < n + 20; c++) begin
      next();
      if (c < n) begin
        req_valid  = ($urandom_range(0, 2) != 0);
        req_warp   = 3'($urandom_range(0, 7));
        req_rs1    = wb_on ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 31));
        req_rs2    = wb_on ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 31));
        req_rs2_en = 1'($urandom_range(0, 1));
        req_mask   = 8'($urandom);
        wb_valid   = wb_on && ($urandom_range(0, 3) == 0);
        wb_warp    = 3'($urandom_range(0, 7));
        wb_addr    = 5'($urandom_range(0, 15));
        wb_mask    = 8'($urandom);
        wb_data    = rand_bus();
        op_ready   = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
      end
      @(negedge clk);
      if (req_valid && req_ready)
        expq.push_back(expect_bundle(req_warp, req_rs1, req_rs2, req_rs2_en, req_mask));
      if (op_valid && op_ready) begin
        if (expq.size() == 0) begin
          chk("rand_unexpected_bundle", op_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          chk("rand_warp", op_warp, e.warp);
          chk("rand_mask", op_mask, e.mask);
          chk("rand_a", op_a, e.a);
          chk("rand_b", op_b, e.b);
        end
      end
      if (wb_valid)
        for (int i = 0; i < LANES; i++) if (wb_mask[i]) shadow[wb_warp][wb_addr][i] = wb_data[i*32 +: 32];
    end
    chk("rand_all_delivered", expq.size(), 0);
  endtask

  bundle_t r1, r2, e;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_warp = '0; req_rs1 = '0; req_rs2 = '0; req_rs2_en = 1'b0;
    req_mask = '0; op_ready = 1'b1;
    wb_valid = 1'b1; wb_warp = 3'd1; wb_addr = 5'd1; wb_mask = 8'hFF; wb_data = '1;
    next(); next();
    @(negedge clk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_write_en", rb_write_en, 0);
    chk("rst_warp_sel", rb_warp_selector, 0);
    chk("rst_op_a", op_a, 0);
    next();
    rst = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);

    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 32; r++) begin
        next();
        wb_write(3'(w), 5'(r), 8'hFF, rand_bus(), 1'b1);
      end

    // Write then single-operand read, full mask
    next();
    wb_write(3'd3, 5'd5, 8'hFF, ramp(32'hA0, 8'hFF), 1'b1);
    @(negedge clk);
    chk("t1_write_en", rb_write_en, 8'hFF);
    chk("t1_waddr", rb_waddr, 5'd5);
    chk("t1_wb_sel", rb_warp_selector, 3'd3);
    next();
    wb_valid = 1'b0;
    req(3'd3, 5'd5, 5'd0, 1'b0, 8'hFF);
    @(negedge clk);
    chk("t1_req_ready", req_ready, 1);
    next();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t1_op_valid_early", op_valid, 0);
    chk("t1_read_en_0", rb_read_en_0, 8'hFF);
    chk("t1_read_en_1", rb_read_en_1, 8'h00);
    chk("t1_raddr_0", rb_raddr_0, 5'd5);
    chk("t1_rd_sel", rb_warp_selector, 3'd3);
    next();
    @(negedge clk);
    chk("t1_op_valid", op_valid, 1);
    chk("t1_op_a", op_a, ramp(32'hA0, 8'hFF));
    chk("t1_op_b", op_b, 0);
    chk("t1_op_warp", op_warp, 3'd3);
    chk("t1_op_mask", op_mask, 8'hFF);

    // Partial mask, both operands
    next();
    req(3'd3, 5'd5, 5'd5, 1'b1, 8'h0F);
    next();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_read_en_0", rb_read_en_0, 8'h0F);
    chk("t2_read_en_1", rb_read_en_1, 8'h0F);
    next();
    @(negedge clk);
    chk("t2_op_valid", op_valid, 1);
    chk("t2_op_a", op_a, ramp(32'hA0, 8'h0F));
    chk("t2_op_b", op_b, ramp(32'hA0, 8'h0F));

    // Back-pressure with two requests back to back
    next();
    op_ready = 1'b0;
    r1 = expect_bundle(3'd0, 5'd16, 5'd17, 1'b1, 8'hA5);
    req(3'd0, 5'd16, 5'd17, 1'b1, 8'hA5);
    next();
    r2 = expect_bundle(3'd6, 5'd18, 5'd19, 1'b1, 8'h3C);
    req(3'd6, 5'd18, 5'd19, 1'b1, 8'h3C);
    @(negedge clk);
    chk("t3_second_accept", req_ready, 1);
    next();
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", op_valid, 1);
      chk("t3_hold_a", op_a, r1.a);
      chk("t3_hold_b", op_b, r1.b);
      chk("t3_req_ready_low", req_ready, 0);
      next();
    end
    op_ready = 1'b1;
    @(negedge clk);
    chk("t3_first_warp", op_warp, r1.warp);
    chk("t3_first_a", op_a, r1.a);
    next();
    @(negedge clk);
    chk("t3_second_valid", op_valid, 1);
    chk("t3_second_mask", op_mask, r2.mask);
    chk("t3_second_a", op_a, r2.a);
    chk("t3_second_b", op_b, r2.b);
    next();
    @(negedge clk);
    chk("t3_drained", op_valid, 0);

    // Same-warp writeback in the read cycle
    req(3'd2, 5'd7, 5'd0, 1'b0, 8'hFF);
    next();
    req_valid = 1'b0;
    wb_write(3'd2, 5'd7, 8'hFF, ramp(32'hDEAD_0000, 8'hFF), 1'b1);
    @(negedge clk);
    chk("t4_wb_sel", rb_warp_selector, 3'd2);
    chk("t4_write_en", rb_write_en, 8'hFF);
`ifdef OPERAND_COLLECTOR_WB_BYPASS_EN
    chk("t4_read_en_same_cycle", rb_read_en_0, 8'hFF);
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_op_valid", op_valid, 1);
    chk("t4_op_a", op_a, ramp(32'hDEAD_0000, 8'hFF));
`else
    chk("t4_read_stalled", rb_read_en_0, 8'h00);
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_op_valid_stall", op_valid, 0);
    chk("t4_read_en_retry", rb_read_en_0, 8'hFF);
    next();
    @(negedge clk);
    chk("t4_op_valid", op_valid, 1);
    chk("t4_op_a", op_a, ramp(32'hDEAD_0000, 8'hFF));
`endif

    // Other-warp writeback during a pending read
    next();
    e = expect_bundle(3'd4, 5'd20, 5'd0, 1'b0, 8'hFF);
    req(3'd4, 5'd20, 5'd0, 1'b0, 8'hFF);
    next();
    req_valid = 1'b0;
    wb_write(3'd1, 5'd3, 8'hFF, rand_bus(), 1'b1);
    @(negedge clk);
    chk("t5_sel_wb", rb_warp_selector, 3'd1);
    chk("t5_read_stalled", rb_read_en_0, 8'h00);
    next();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t5_sel_read", rb_warp_selector, 3'd4);
    chk("t5_read_en", rb_read_en_0, 8'hFF);
    next();
    @(negedge clk);
    chk("t5_op_valid", op_valid, 1);
    chk("t5_op_a", op_a, e.a);

    // Reset with a pending request and a held bundle
    next();
    op_ready = 1'b0;
    req(3'd5, 5'd21, 5'd22, 1'b1, 8'hFF);
    next();
    req(3'd5, 5'd23, 5'd24, 1'b1, 8'hFF);
    next();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_setup_valid", op_valid, 1);
    next();
    rst = 1'b1;
    wb_write(3'd6, 5'd9, 8'hFF, rand_bus(), 1'b0);
    @(negedge clk);
    chk("t6_rst_write_en", rb_write_en, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_read_en", rb_read_en_0, 0);
    next();
    rst = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
    @(negedge clk);
    chk("t6_op_valid", op_valid, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_read_en_0", rb_read_en_0, 0);
    chk("t6_read_en_1", rb_read_en_1, 0);
    chk("t6_write_en", rb_write_en, 0);
    chk("t6_sel", rb_warp_selector, 0);
    chk("t6_raddr_0", rb_raddr_0, 0);
    chk("t6_waddr", rb_waddr, 0);
    e = expect_bundle(3'd6, 5'd9, 5'd0, 1'b0, 8'hFF);
    req(3'd6, 5'd9, 5'd0, 1'b0, 8'hFF);
    next();
    req_valid = 1'b0;
    next();
    @(negedge clk);
    chk("t6_no_write_in_reset", op_a, e.a);

    run_random(300, 1'b1);
    run_random(150, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
